// File: rtl/mmio_io_responder_if.sv
// Bus-side signal bundle between the memory controller and the MMIO responder.
//
// Handshake: there is no ready. wr_en and rd_en are single-cycle strobes that
// the responder always accepts on the edge where they are high. A write
// updates its target register on that edge. A read that hits the button
// array returns io_rd_valid high for exactly one cycle, one edge later,
// with io_rd_data holding the status word. io_rd_data is zero whenever
// io_rd_valid is low. When both strobes are high together, the write is
// taken and the read is dropped.
interface mmio_io_responder_if #(
  parameter int data_width = 32
);
  logic                  wr_en;
  logic                  rd_en;
  logic [4:0]            sel_mux_data_in;
  logic [4:0]            sel_mux_data_out;
  logic [data_width-1:0] wr_data;
  logic [data_width-1:0] io_rd_data;
  logic                  io_rd_valid;

  modport master (
    output wr_en, rd_en, sel_mux_data_in, sel_mux_data_out, wr_data,
    input  io_rd_data, io_rd_valid
  );

  modport slave (
    input  wr_en, rd_en, sel_mux_data_in, sel_mux_data_out, wr_data,
    output io_rd_data, io_rd_valid
  );
endinterface

// File: rtl/mmio_io_responder.sv
// MMIO responder: two seven-segment output registers plus a synchronised,
// debounced button array that can be read as a status word. Press flags in
// the status word are sticky and are cleared when a status read completes.
module mmio_io_responder #(
  parameter int data_width      = 32,
  parameter int seg_width       = 8,
  parameter int num_buttons     = 4,
  parameter int debounce_cycles = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  mmio_io_responder_if.slave     bus,
  input  logic [num_buttons-1:0] i_btn_raw,
  output logic [seg_width-1:0]   o_seg0,
  output logic [seg_width-1:0]   o_seg1,
  output logic [num_buttons-1:0] o_dbg_deb,
  output logic [num_buttons-1:0] o_dbg_flags
);

  localparam int             CNT_W       = $clog2(debounce_cycles);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(debounce_cycles - 1);
  localparam logic [4:0]     SEL_IN_SEG0 = 5'd1;
  localparam logic [4:0]     SEL_IN_SEG1 = 5'd2;
  localparam logic [4:0]     SEL_OUT_BTN = 5'd1;
  localparam int             FLAG_LSB    = 16;

  // Registered state
  logic [num_buttons-1:0] r_sync1;
  logic [num_buttons-1:0] r_sync2;
  logic [num_buttons-1:0] r_deb;
  logic [num_buttons-1:0] r_flags;
  logic [CNT_W-1:0]       r_cnt [num_buttons];
  logic [seg_width-1:0]   r_seg0;
  logic [seg_width-1:0]   r_seg1;
  logic [data_width-1:0]  r_rd_data;
  logic                   r_rd_valid;

  // Combinational next-state
  logic                   w_wr_seg0;
  logic                   w_wr_seg1;
  logic                   w_rd_hit;
  logic [num_buttons-1:0] w_deb_next;
  logic [CNT_W-1:0]       w_cnt_next [num_buttons];
  logic [num_buttons-1:0] w_rise;
  logic [num_buttons-1:0] w_flags_next;
  logic [data_width-1:0]  w_status;
  logic                   w_unused_wr_bits;

  // Only the low seg_width bits of the write data reach a register.
  assign w_unused_wr_bits = &{1'b0, bus.wr_data};

  // Access decode; a write always wins over a read in the same cycle.
  assign w_wr_seg0 = bus.wr_en && (bus.sel_mux_data_in == SEL_IN_SEG0);
  assign w_wr_seg1 = bus.wr_en && (bus.sel_mux_data_in == SEL_IN_SEG1);
  assign w_rd_hit  = bus.rd_en && !bus.wr_en && (bus.sel_mux_data_out == SEL_OUT_BTN);

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= i_btn_raw;
      r_sync2 <= r_sync1;
    end
  end

  // Per-button debounce: a disagreement must persist debounce_cycles edges.
  always_comb begin
    w_deb_next = r_deb;
    for (int b = 0; b < num_buttons; b++) begin
      w_cnt_next[b] = '0;
      if (r_sync2[b] != r_deb[b]) begin
        if (r_cnt[b] == CNT_LAST) begin
          w_deb_next[b] = r_sync2[b];
        end else begin
          w_cnt_next[b] = r_cnt[b] + CNT_W'(1);
        end
      end
    end
  end

  // Rising debounced edges set flags; a completed status read clears them,
  // but a rise on the same edge as the clearing read survives.
  always_comb begin
    w_rise       = w_deb_next & ~r_deb;
    w_flags_next = ({num_buttons{~w_rd_hit}} & r_flags) | w_rise;
  end

  // Status word built from pre-edge state so a read sees flags before clear.
  always_comb begin
    w_status                              = '0;
    w_status[num_buttons-1:0]             = r_deb;
    w_status[FLAG_LSB +: num_buttons]     = r_flags;
  end

  // Debounced level, debounce counters and sticky press flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb   <= '0;
      r_flags <= '0;
      for (int b = 0; b < num_buttons; b++) begin
        r_cnt[b] <= '0;
      end
    end else begin
      r_deb   <= w_deb_next;
      r_flags <= w_flags_next;
      for (int b = 0; b < num_buttons; b++) begin
        r_cnt[b] <= w_cnt_next[b];
      end
    end
  end

  // Segment output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_seg0 <= '0;
      r_seg1 <= '0;
    end else begin
      if (w_wr_seg0) r_seg0 <= bus.wr_data[seg_width-1:0];
      if (w_wr_seg1) r_seg1 <= bus.wr_data[seg_width-1:0];
    end
  end

  // Registered read response: one valid cycle per hitting strobe, else zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
    end else begin
      r_rd_valid <= w_rd_hit;
      r_rd_data  <= w_rd_hit ? w_status : '0;
    end
  end

  assign o_seg0          = r_seg0;
  assign o_seg1          = r_seg1;
  assign o_dbg_deb       = r_deb;
  assign o_dbg_flags     = r_flags;
  assign bus.io_rd_data  = r_rd_data;
  assign bus.io_rd_valid = r_rd_valid;

endmodule

// File: tb/tb_mmio_io_responder.sv
// Bench for mmio_io_responder: directed stimulus, a history-based reference
// model compared every cycle, and literal checkpoints at the key edges.
module tb_mmio_io_responder;

  localparam int DW = 32;
  localparam int SW = 8;
  localparam int NB = 4;
  localparam int DC = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mmio_io_responder_if #(.data_width(DW)) bus ();
  logic [NB-1:0] btn_raw;
  logic [SW-1:0] seg0;
  logic [SW-1:0] seg1;
  logic [NB-1:0] dbg_deb;
  logic [NB-1:0] dbg_flags;

  mmio_io_responder #(
    .data_width(DW), .seg_width(SW), .num_buttons(NB), .debounce_cycles(DC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .i_btn_raw(btn_raw),
    .o_seg0(seg0),
    .o_seg1(seg1),
    .o_dbg_deb(dbg_deb),
    .o_dbg_flags(dbg_flags)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounced level flips once the doubly-delayed pin level has disagreed
  // with it on each of the last DC edges since its previous flip.
  logic [SW-1:0] m_seg0, m_seg1;
  logic          m_rd_valid;
  logic [DW-1:0] m_rd_data;
  logic [NB-1:0] m_deb, m_flags;
  logic [NB-1:0] raw_h[$];
  logic [NB-1:0] sync_h[$];
  int            m_edge;
  int            last_flip[NB];

  task automatic m_reset();
    m_seg0 = '0; m_seg1 = '0; m_rd_valid = 1'b0; m_rd_data = '0;
    m_deb = '0; m_flags = '0; m_edge = 0;
    raw_h.delete(); sync_h.delete();
    for (int b = 0; b < NB; b++) last_flip[b] = 0;
  endtask

  task automatic m_step();
    logic [NB-1:0] s, new_deb;
    logic          hit, all_diff;
    logic [DW-1:0] st;
    m_edge++;
    raw_h.push_back(btn_raw);
    s = (m_edge >= 3) ? raw_h[m_edge-3] : '0;
    sync_h.push_back(s);
    new_deb = m_deb;
    for (int b = 0; b < NB; b++) begin
      if (m_edge - last_flip[b] >= DC) begin
        all_diff = 1'b1;
        for (int k = 0; k < DC; k++)
          if (sync_h[m_edge-1-k][b] == m_deb[b]) all_diff = 1'b0;
        if (all_diff) begin
          new_deb[b]   = ~m_deb[b];
          last_flip[b] = m_edge;
        end
      end
    end
    hit = bus.rd_en && !bus.wr_en && (bus.sel_mux_data_out == 5'd1);
    st = '0;
    st[NB-1:0] = m_deb;
    st[16 +: NB] = m_flags;
    m_rd_valid = hit;
    m_rd_data  = hit ? st : '0;
    m_flags    = (hit ? '0 : m_flags) | (new_deb & ~m_deb);
    m_deb      = new_deb;
    if (bus.wr_en && bus.sel_mux_data_in == 5'd1) m_seg0 = bus.wr_data[SW-1:0];
    if (bus.wr_en && bus.sel_mux_data_in == 5'd2) m_seg1 = bus.wr_data[SW-1:0];
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else m_step();
    end
  end

  // ---------------- scoreboard compare, every cycle ----------------
  initial begin
    forever begin
      @(negedge clk);
      check("cyc_seg0",     32'(seg0),            32'(m_seg0));
      check("cyc_seg1",     32'(seg1),            32'(m_seg1));
      check("cyc_rd_valid", 32'(bus.io_rd_valid), 32'(m_rd_valid));
      check("cyc_rd_data",  bus.io_rd_data,       m_rd_data);
      check("cyc_deb",      32'(dbg_deb),         32'(m_deb));
      check("cyc_flags",    32'(dbg_flags),       32'(m_flags));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic do_write(input logic [4:0] sel, input logic [31:0] data);
    bus.wr_en = 1'b1; bus.sel_mux_data_in = sel; bus.wr_data = data;
    tick(1);
    bus.wr_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b1;
    btn_raw = 4'hF;
    bus.wr_en = 1'b0; bus.rd_en = 1'b0;
    bus.sel_mux_data_in = 5'd0; bus.sel_mux_data_out = 5'd0;
    bus.wr_data = '0;

    // Reset with all buttons held.
    tick(3);
    check("rst_seg0",  32'(seg0), 32'h0);
    check("rst_seg1",  32'(seg1), 32'h0);
    check("rst_valid", 32'(bus.io_rd_valid), 32'h0);
    check("rst_data",  bus.io_rd_data, 32'h0);
    check("rst_deb",   32'(dbg_deb), 32'h0);
    rst = 1'b0;
    tick(17);
    check("boot_deb_e17", 32'(dbg_deb), 32'h0);
    tick(1);
    check("boot_deb_e18",   32'(dbg_deb),   32'hF);
    check("boot_flags_e18", 32'(dbg_flags), 32'hF);
    bus.rd_en = 1'b1; bus.sel_mux_data_out = 5'd1;
    tick(1);
    bus.rd_en = 1'b0;
    check("boot_rd_valid", 32'(bus.io_rd_valid), 32'h1);
    check("boot_rd_data",  bus.io_rd_data, 32'h000F_000F);
    tick(1);
    check("boot_rd_drop",  32'(bus.io_rd_valid), 32'h0);
    check("boot_flags_clr", 32'(dbg_flags), 32'h0);
    btn_raw = 4'h0;
    tick(20);

    // Segment writes, including ignored codes.
    do_write(5'd1, 32'h1234_56A5);
    check("wr_seg0", 32'(seg0), 32'hA5);
    check("wr_seg1_hold", 32'(seg1), 32'h00);
    do_write(5'd2, 32'h0000_003C);
    check("wr_seg1", 32'(seg1), 32'h3C);
    do_write(5'd0, 32'hFFFF_FFFF);
    do_write(5'd7, 32'h0000_0055);
    check("wr_ignored_seg0", 32'(seg0), 32'hA5);
    check("wr_ignored_seg1", 32'(seg1), 32'h3C);

    // Bounce filtering on button 0.
    for (int i = 0; i < 60; i++) begin
      btn_raw[0] = ((i / 5) % 2 == 0);
      tick(1);
      if (dbg_deb[0] !== 1'b0) check("bounce_deb0", 32'(dbg_deb[0]), 32'h0);
    end
    btn_raw[0] = 1'b1;
    tick(17);
    check("bounce_deb_e17", 32'(dbg_deb), 32'h0);
    tick(1);
    check("bounce_deb_e18",   32'(dbg_deb),   32'h1);
    check("bounce_flag_e18",  32'(dbg_flags), 32'h1);
    bus.rd_en = 1'b1;
    tick(1);
    bus.rd_en = 1'b0;
    check("bounce_rd_data", bus.io_rd_data, 32'h0001_0001);
    btn_raw = 4'h0;
    tick(20);

    // Read-to-clear on button 2, back-to-back reads.
    btn_raw = 4'h4;
    tick(20);
    bus.rd_en = 1'b1;
    tick(1);
    check("rtc_valid1", 32'(bus.io_rd_valid), 32'h1);
    check("rtc_data1",  bus.io_rd_data, 32'h0004_0004);
    tick(1);
    bus.rd_en = 1'b0;
    check("rtc_valid2", 32'(bus.io_rd_valid), 32'h1);
    check("rtc_data2",  bus.io_rd_data, 32'h0000_0004);
    tick(1);
    check("rtc_valid_off", 32'(bus.io_rd_valid), 32'h0);
    check("rtc_data_off",  bus.io_rd_data, 32'h0);
    btn_raw = 4'h0;
    tick(20);

    // Same-edge race: read lands on the edge deb[1] rises.
    btn_raw = 4'h2;
    tick(17);
    check("race_deb_e17", 32'(dbg_deb), 32'h0);
    bus.rd_en = 1'b1;
    tick(1);
    check("race_rd_data",   bus.io_rd_data, 32'h0);
    check("race_rd_valid",  32'(bus.io_rd_valid), 32'h1);
    check("race_flag_kept", 32'(dbg_flags), 32'h2);
    tick(1);
    bus.rd_en = 1'b0;
    check("race_rd_next", bus.io_rd_data, 32'h0002_0002);
    tick(1);
    check("race_flags_clr", 32'(dbg_flags), 32'h0);

    // Write/read collision while a flag is pending.
    btn_raw = 4'h3;
    tick(20);
    bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    bus.sel_mux_data_in = 5'd1; bus.sel_mux_data_out = 5'd1;
    bus.wr_data = 32'hFFFF_FF5A;
    tick(1);
    bus.wr_en = 1'b0;
    check("coll_seg0",  32'(seg0), 32'h5A);
    check("coll_valid", 32'(bus.io_rd_valid), 32'h0);
    check("coll_data",  bus.io_rd_data, 32'h0);
    check("coll_flags", 32'(dbg_flags), 32'h1);
    tick(1);
    bus.rd_en = 1'b0;
    check("coll_rd_after", bus.io_rd_data, 32'h0001_0003);

    // Reset in the middle of a debounce on button 3.
    btn_raw = 4'h0;
    tick(20);
    btn_raw = 4'h8;
    tick(10);
    check("mid_deb_pending", 32'(dbg_deb), 32'h0);
    rst = 1'b1;
    tick(2);
    check("mid_rst_seg0", 32'(seg0), 32'h0);
    check("mid_rst_deb",  32'(dbg_deb), 32'h0);
    rst = 1'b0;
    tick(17);
    check("mid_deb_e17", 32'(dbg_deb), 32'h0);
    tick(1);
    check("mid_deb_e18",   32'(dbg_deb),   32'h8);
    check("mid_flags_e18", 32'(dbg_flags), 32'h8);

    tick(3);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
